// File: rtl/m2_serializer.sv
// m2_serializer: fetches 12-bit words from a filler stage and shifts them out
// MSB first, one bit per BIT_DIV clocks. The next word is prefetched during the
// last bit period, so consecutive words are sent back to back with no gap.
// Optional feature macro: M2_PARITY_EN appends an odd-parity bit after bit 0,
// giving 13 bit periods per word.
//
// Handshake with the filler stage: bufGetWord is a one-cycle strobe and
// bufRdPointer is valid while it is high; the filler presents dataWord on the
// following cycle and holds it until the next strobe. There is no back-pressure.
module m2_serializer #(
  parameter int BIT_DIV  = 10,
  parameter int LAST_PTR = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [11:0] dataWord,
  output logic        bufGetWord,
  output logic [7:0]  bufRdPointer,
  output logic        serOut,
  output logic        bitStrobe,
  output logic        frameStart,
  output logic        busy,
  output logic [1:0]  dbg_state_o
);

`ifdef M2_PARITY_EN
  localparam int NB = 13;
`else
  localparam int NB = 12;
`endif

  localparam logic [3:0] BIT_TOP  = 4'(NB - 1);
  localparam logic [7:0] DIV_LAST = 8'(BIT_DIV - 1);
  localparam logic [7:0] PTR_LAST = 8'(LAST_PTR);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_LOAD  = 2'd2,
    S_SHIFT = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      ptr_q, ptr_d;
  logic [NB-1:0]   sh_q, sh_d;
  logic [NB-1:0]   hold_q, hold_d;
  logic [7:0]      div_q, div_d;
  logic [3:0]      bit_q, bit_d;
  logic            pref_q, pref_d;
  logic            cap_q, cap_d;

  logic            first_clk;
  logic            last_bit;
  logic            bit_end;
  logic [7:0]      ptr_next;

  // Turns a raw data word into the bit sequence that goes on the line.
  function automatic logic [NB-1:0] fmt_word(input logic [11:0] d);
`ifdef M2_PARITY_EN
    fmt_word = {d, ~(^d)};
`else
    fmt_word = d;
`endif
  endfunction

  assign first_clk = (div_q == 8'd0);
  assign last_bit  = (bit_q == 4'd0);
  assign bit_end   = (div_q == DIV_LAST);
  assign ptr_next  = (ptr_q == PTR_LAST) ? 8'd0 : ptr_q + 8'd1;

  // State and datapath registers; reset aborts any word in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      ptr_q   <= 8'd0;
      sh_q    <= '0;
      hold_q  <= '0;
      div_q   <= 8'd0;
      bit_q   <= 4'd0;
      pref_q  <= 1'b0;
      cap_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sh_q    <= sh_d;
      hold_q  <= hold_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      pref_q  <= pref_d;
      cap_q   <= cap_d;
    end
  end

  // Next-state logic, fetch strobes and bit timing.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    sh_d         = sh_q;
    hold_d       = hold_q;
    div_d        = div_q;
    bit_d        = bit_q;
    pref_d       = pref_q;
    cap_d        = 1'b0;
    bufGetWord   = 1'b0;
    bufRdPointer = ptr_q;

    // The prefetched word arrives the cycle after its strobe.
    if (cap_q) hold_d = fmt_word(dataWord);

    case (state_q)
      S_IDLE: begin
        if (enable) state_d = S_REQ;
      end
      S_REQ: begin
        bufGetWord = 1'b1;
        state_d    = S_LOAD;
      end
      S_LOAD: begin
        sh_d    = fmt_word(dataWord);
        bit_d   = BIT_TOP;
        div_d   = 8'd0;
        pref_d  = 1'b0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        // enable is only looked at here, so mid-word changes cannot disturb
        // the word currently on the line.
        if (first_clk && last_bit && enable) begin
          bufGetWord   = 1'b1;
          bufRdPointer = ptr_next;
          ptr_d        = ptr_next;
          pref_d       = 1'b1;
          cap_d        = 1'b1;
        end
        if (bit_end) begin
          div_d = 8'd0;
          if (!last_bit) begin
            sh_d  = sh_q << 1;
            bit_d = bit_q - 4'd1;
          end else if (pref_q) begin
            sh_d   = hold_q;
            bit_d  = BIT_TOP;
            pref_d = 1'b0;
          end else begin
            // Stopping: advance past the word just sent so a restart resumes
            // at the next one.
            ptr_d   = ptr_next;
            state_d = S_IDLE;
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The pointer register always names the word on the line at its first bit.
  assign serOut      = (state_q == S_SHIFT) & sh_q[NB-1];
  assign bitStrobe   = (state_q == S_SHIFT) & first_clk;
  assign frameStart  = bitStrobe & (bit_q == BIT_TOP) & (ptr_q == 8'd0);
  assign busy        = (state_q != S_IDLE);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_m2_serializer.sv
// Self-checking bench for m2_serializer (BIT_DIV=10, LAST_PTR=3).
// A filler model serves words from a memory; a negedge monitor records fetches,
// bit strobes and frame pulses; each test compares the record against words
// and pointers predicted from the serializer's rules.
module tb_m2_serializer;
  localparam int BIT_DIV  = 10;
  localparam int LAST_PTR = 3;
`ifdef M2_PARITY_EN
  localparam int NB = 13;
`else
  localparam int NB = 12;
`endif

  logic        clk;
  logic        reset;
  logic        enable;
  logic [11:0] dataWord;
  logic        bufGetWord;
  logic [7:0]  bufRdPointer;
  logic        serOut;
  logic        bitStrobe;
  logic        frameStart;
  logic        busy;
  logic [1:0]  dbg_state_o;

  m2_serializer #(.BIT_DIV(BIT_DIV), .LAST_PTR(LAST_PTR)) dut (
    .clk(clk), .reset(reset), .enable(enable), .dataWord(dataWord),
    .bufGetWord(bufGetWord), .bufRdPointer(bufRdPointer), .serOut(serOut),
    .bitStrobe(bitStrobe), .frameStart(frameStart), .busy(busy),
    .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // ---------------- filler model and monitor ----------------
  logic [11:0] mem [0:255];
  logic [7:0]  fill_ptr;
  logic        fill_tog  = 1'b0;
  logic        fill_seen = 1'b0;

  int   get_ptr_q[$];
  int   get_cyc_q[$];
  int   stb_cyc_q[$];
  int   frm_cyc_q[$];
  logic ser_q[$];
  logic [NB-1:0] exp_q[$];
  int   hold_err = 0;
  int   dbl_err  = 0;
  logic in_bits  = 1'b0;
  logic last_ser = 1'b0;
  logic prev_get = 1'b0;

  // Word is presented just after the edge that ends the strobe cycle.
  always @(posedge clk) begin
    #1;
    if (fill_tog !== fill_seen) begin
      fill_seen = fill_tog;
      dataWord  = mem[fill_ptr];
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      in_bits  = 1'b0;
      prev_get = 1'b0;
    end else begin
      if (bufGetWord) begin
        get_ptr_q.push_back(int'(bufRdPointer));
        get_cyc_q.push_back(cyc);
        if (prev_get) dbl_err++;
        fill_ptr = bufRdPointer;
        fill_tog = ~fill_tog;
      end
      prev_get = bufGetWord;
      if (bitStrobe) begin
        stb_cyc_q.push_back(cyc);
        ser_q.push_back(serOut);
        last_ser = serOut;
        in_bits  = 1'b1;
      end else if (in_bits && busy && (serOut !== last_ser)) begin
        hold_err++;
      end
      if (!busy) in_bits = 1'b0;
      if (frameStart) frm_cyc_q.push_back(cyc);
    end
  end

  // ---------------- reference model / record access ----------------
  int n_checks = 0;
  int n_pass   = 0;

  function automatic logic [NB-1:0] tb_word(input logic [11:0] d);
`ifdef M2_PARITY_EN
    // odd parity: the 13 bits together carry an odd number of ones
    tb_word = {d, ($countones(d) % 2 == 0) ? 1'b1 : 1'b0};
`else
    tb_word = d;
`endif
  endfunction

  function automatic int q_at(input int q[$], input int i);
    q_at = (i < q.size()) ? q[i] : -1;
  endfunction

  function automatic logic [NB-1:0] got_word(input int from);
    logic [NB-1:0] w;
    w = '0;
    for (int i = 0; i < NB; i++)
      w = {w[NB-2:0], (from + i < ser_q.size()) ? ser_q[from + i] : 1'bx};
    got_word = w;
  endfunction

  function automatic int bad_periods(input int from, input int n);
    int bad;
    bad = 0;
    for (int i = 1; i < n; i++)
      if (q_at(stb_cyc_q, from + i) - q_at(stb_cyc_q, from + i - 1) != BIT_DIV) bad++;
    bad_periods = bad;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_strobes(input int n, input int budget, output bit to);
    to = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (stb_cyc_q.size() >= n) begin to = 1'b0; break; end
    end
  endtask

  task automatic wait_gets(input int n, input int budget, output bit to);
    to = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (get_ptr_q.size() >= n) begin to = 1'b0; break; end
    end
  endtask

  task automatic wait_idle(input int budget, output bit to);
    to = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin to = 1'b0; break; end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [4:0] outs;
    enable = 1'b1;
    reset  = 1'b1;
    repeat (3) @(negedge clk);
    outs = {bufGetWord, serOut, bitStrobe, frameStart, busy};
    n_checks++;
    if (outs !== 5'b0) $display("FAIL reset_outputs: got %b want 00000", outs);
    else n_pass++;
    n_checks++;
    if (bufRdPointer !== 8'd0) $display("FAIL reset_pointer: got %0d want 0", bufRdPointer);
    else n_pass++;
    n_checks++;
    if (dbg_state_o !== 2'd0) $display("FAIL reset_state: got %0d want 0", dbg_state_o);
    else n_pass++;
    reset  = 1'b0;
    enable = 1'b0;
  endtask

  task automatic test_first_fetch();
    int gb, sb, fb, he;
    bit to;
    logic [NB-1:0] w;
    mem[0] = 12'hA5C;
    gb = get_ptr_q.size(); sb = stb_cyc_q.size(); fb = frm_cyc_q.size(); he = hold_err;
    enable = 1'b1;
    apply_reset();
    wait_strobes(sb + 1, 20, to);
    enable = 1'b0;
    n_checks++;
    if (to) $display("FAIL ff_start_timeout: got no strobe want strobe within 20 cycles");
    else n_pass++;
    wait_idle(NB * BIT_DIV + 50, to);
    n_checks++;
    if (to) $display("FAIL ff_idle_timeout: got busy want idle");
    else n_pass++;
    n_checks++;
    if (get_ptr_q.size() - gb != 1) $display("FAIL ff_fetch_count: got %0d want 1", get_ptr_q.size() - gb);
    else n_pass++;
    n_checks++;
    if (q_at(get_cyc_q, gb) != 1) $display("FAIL ff_fetch_cycle: got %0d want 1", q_at(get_cyc_q, gb));
    else n_pass++;
    n_checks++;
    if (q_at(get_ptr_q, gb) != 0) $display("FAIL ff_fetch_ptr: got %0d want 0", q_at(get_ptr_q, gb));
    else n_pass++;
    n_checks++;
    if (q_at(stb_cyc_q, sb) != 3) $display("FAIL ff_first_bit_cycle: got %0d want 3", q_at(stb_cyc_q, sb));
    else n_pass++;
    n_checks++;
    if (frm_cyc_q.size() - fb != 1 || q_at(frm_cyc_q, fb) != 3)
      $display("FAIL ff_frame_start: got count %0d cycle %0d want count 1 cycle 3",
               frm_cyc_q.size() - fb, q_at(frm_cyc_q, fb));
    else n_pass++;
    n_checks++;
    if (stb_cyc_q.size() - sb != NB) $display("FAIL ff_bit_count: got %0d want %0d", stb_cyc_q.size() - sb, NB);
    else n_pass++;
    exp_q.push_back(tb_word(mem[0]));
    w = exp_q.pop_front();
    n_checks++;
    if (got_word(sb) !== w) $display("FAIL ff_word_bits: got %b want %b", got_word(sb), w);
    else n_pass++;
    n_checks++;
    if (bad_periods(sb, NB) != 0) $display("FAIL ff_bit_period: got %0d bad periods want 0", bad_periods(sb, NB));
    else n_pass++;
    n_checks++;
    if (hold_err != he) $display("FAIL ff_bit_hold: got %0d mid-bit changes want 0", hold_err - he);
    else n_pass++;
    n_checks++;
    if (bufRdPointer !== 8'd1) $display("FAIL ff_resume_ptr: got %0d want 1", bufRdPointer);
    else n_pass++;
  endtask

  task automatic test_continuous();
    int gb, sb, fb, de, bad;
    bit to, t2;
    logic [NB-1:0] w;
    for (int i = 0; i <= LAST_PTR; i++) mem[i] = 12'($urandom_range(0, 4095));
    gb = get_ptr_q.size(); sb = stb_cyc_q.size(); fb = frm_cyc_q.size(); de = dbl_err;
    enable = 1'b1;
    apply_reset();
    wait_strobes(sb + 4 * NB + 1, 5 * NB * BIT_DIV + 50, to);
    enable = 1'b0;
    wait_idle(NB * BIT_DIV + 50, t2);
    n_checks++;
    if (to || t2) $display("FAIL cont_timeout: got start_to=%0d idle_to=%0d want 0 0", to, t2);
    else n_pass++;
    n_checks++;
    if (get_ptr_q.size() - gb != 5) $display("FAIL cont_fetch_count: got %0d want 5", get_ptr_q.size() - gb);
    else n_pass++;
    bad = 0;
    for (int i = 0; i < 5; i++) if (q_at(get_ptr_q, gb + i) != i % (LAST_PTR + 1)) bad++;
    n_checks++;
    if (bad != 0) $display("FAIL cont_ptr_seq: got %0d wrong pointers want 0", bad);
    else n_pass++;
    for (int i = 0; i < 5; i++) exp_q.push_back(tb_word(mem[i % (LAST_PTR + 1)]));
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      w = exp_q.pop_front();
      if (got_word(sb + i * NB) !== w) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL cont_words: got %0d wrong words want 0", bad);
    else n_pass++;
    n_checks++;
    if (stb_cyc_q.size() - sb != 5 * NB) $display("FAIL cont_bit_count: got %0d want %0d", stb_cyc_q.size() - sb, 5 * NB);
    else n_pass++;
    n_checks++;
    if (bad_periods(sb, 5 * NB) != 0) $display("FAIL cont_no_gap: got %0d bad periods want 0", bad_periods(sb, 5 * NB));
    else n_pass++;
    n_checks++;
    if (frm_cyc_q.size() - fb != 2 || q_at(frm_cyc_q, fb) != q_at(stb_cyc_q, sb) ||
        q_at(frm_cyc_q, fb + 1) != q_at(stb_cyc_q, sb + 4 * NB))
      $display("FAIL cont_frames: got count %0d at %0d,%0d want 2 at %0d,%0d", frm_cyc_q.size() - fb,
               q_at(frm_cyc_q, fb), q_at(frm_cyc_q, fb + 1), q_at(stb_cyc_q, sb), q_at(stb_cyc_q, sb + 4 * NB));
    else n_pass++;
    n_checks++;
    if (dbl_err != de) $display("FAIL cont_single_strobe: got %0d double strobes want 0", dbl_err - de);
    else n_pass++;
  endtask

  task automatic test_enable_drop();
    int gb, sb, fb, bad;
    bit to, t2;
    logic [NB-1:0] w;
    for (int i = 0; i <= LAST_PTR; i++) mem[i] = 12'($urandom_range(0, 4095));
    gb = get_ptr_q.size(); sb = stb_cyc_q.size(); fb = frm_cyc_q.size();
    enable = 1'b1;
    apply_reset();
    // strobe index 2*NB+6 is bit 5 of word 2
    wait_strobes(sb + 2 * NB + 7, 4 * NB * BIT_DIV, to);
    enable = 1'b0;
    wait_idle(2 * NB * BIT_DIV, t2);
    n_checks++;
    if (to || t2) $display("FAIL drop_timeout: got start_to=%0d idle_to=%0d want 0 0", to, t2);
    else n_pass++;
    bad = 0;
    for (int i = 0; i < 3; i++) if (q_at(get_ptr_q, gb + i) != i) bad++;
    n_checks++;
    if (get_ptr_q.size() - gb != 3 || bad != 0)
      $display("FAIL drop_fetches: got %0d fetches %0d wrong want 3 fetches 0 wrong", get_ptr_q.size() - gb, bad);
    else n_pass++;
    for (int i = 0; i < 3; i++) exp_q.push_back(tb_word(mem[i]));
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      w = exp_q.pop_front();
      if (got_word(sb + i * NB) !== w) bad++;
    end
    n_checks++;
    if (bad != 0 || stb_cyc_q.size() - sb != 3 * NB)
      $display("FAIL drop_word2_complete: got %0d bits %0d bad words want %0d bits 0 bad", stb_cyc_q.size() - sb, bad, 3 * NB);
    else n_pass++;
    n_checks++;
    if (frm_cyc_q.size() - fb != 1) $display("FAIL drop_frames: got %0d want 1", frm_cyc_q.size() - fb);
    else n_pass++;
    n_checks++;
    if (bufRdPointer !== 8'd3 || dbg_state_o !== 2'd0)
      $display("FAIL drop_idle_ptr: got ptr %0d state %0d want ptr 3 state 0", bufRdPointer, dbg_state_o);
    else n_pass++;
    // resume
    gb = get_ptr_q.size(); sb = stb_cyc_q.size();
    enable = 1'b1;
    wait_gets(gb + 1, 20, to);
    n_checks++;
    if (to || q_at(get_ptr_q, gb) != 3) $display("FAIL drop_resume_ptr: got %0d want 3", q_at(get_ptr_q, gb));
    else n_pass++;
    wait_strobes(sb + 1, 20, to);
    enable = 1'b0;
    wait_idle(NB * BIT_DIV + 50, t2);
    exp_q.push_back(tb_word(mem[3]));
    w = exp_q.pop_front();
    n_checks++;
    if (to || t2 || got_word(sb) !== w) $display("FAIL drop_resume_word: got %b want %b", got_word(sb), w);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int gb, sb;
    bit to;
    logic [4:0] outs;
    for (int i = 0; i <= LAST_PTR; i++) mem[i] = 12'($urandom_range(0, 4095));
    sb = stb_cyc_q.size();
    enable = 1'b1;
    apply_reset();
    // strobe index NB+4 is bit 7 of word 1
    wait_strobes(sb + NB + 5, 3 * NB * BIT_DIV, to);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    outs = {bufGetWord, serOut, bitStrobe, frameStart, busy};
    n_checks++;
    if (to || outs !== 5'b0 || bufRdPointer !== 8'd0)
      $display("FAIL rstmid_outputs: got outs %b ptr %0d want 00000 ptr 0", outs, bufRdPointer);
    else n_pass++;
    @(negedge clk);
    gb = get_ptr_q.size();
    reset = 1'b0;
    wait_gets(gb + 1, 20, to);
    n_checks++;
    if (to || q_at(get_ptr_q, gb) != 0 || q_at(get_cyc_q, gb) != 1)
      $display("FAIL rstmid_refetch: got ptr %0d cycle %0d want ptr 0 cycle 1", q_at(get_ptr_q, gb), q_at(get_cyc_q, gb));
    else n_pass++;
    enable = 1'b0;
    wait_idle(NB * BIT_DIV + 50, to);
  endtask

  // Random run lengths with mid-word enable glitches; the pointer carries
  // across runs without reset.
  task automatic test_random_runs();
    int gb, sb, k, p, bad;
    bit to, t2;
    logic [NB-1:0] w;
    enable = 1'b0;
    apply_reset();
    p = 0;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i <= LAST_PTR; i++) mem[i] = 12'($urandom_range(0, 4095));
      k = $urandom_range(1, 4);
      gb = get_ptr_q.size(); sb = stb_cyc_q.size();
      t2 = 1'b0;
      enable = 1'b1;
      for (int j = 0; j < k; j++) begin
        wait_strobes(sb + j * NB + 4, 2 * NB * BIT_DIV, to);
        t2 = t2 | to;
        enable = 1'b0;
        if (j != k - 1) begin
          repeat (4) @(negedge clk);
          enable = 1'b1;
        end
      end
      wait_idle(2 * NB * BIT_DIV, to);
      t2 = t2 | to;
      for (int j = 0; j < k; j++) exp_q.push_back(tb_word(mem[(p + j) % (LAST_PTR + 1)]));
      bad = 0;
      for (int j = 0; j < k; j++) begin
        w = exp_q.pop_front();
        if (got_word(sb + j * NB) !== w) bad++;
        if (q_at(get_ptr_q, gb + j) != (p + j) % (LAST_PTR + 1)) bad++;
      end
      n_checks++;
      if (t2 || bad != 0 || get_ptr_q.size() - gb != k || stb_cyc_q.size() - sb != k * NB)
        $display("FAIL rand_run%0d: got %0d fetches %0d bits %0d errors want %0d fetches %0d bits 0 errors",
                 r, get_ptr_q.size() - gb, stb_cyc_q.size() - sb, bad, k, k * NB);
      else n_pass++;
      p = (p + k) % (LAST_PTR + 1);
    end
  endtask

`ifdef M2_PARITY_EN
  task automatic test_parity();
    int sb;
    bit to, t2;
    mem[0] = 12'h001;
    mem[1] = 12'h003;
    sb = stb_cyc_q.size();
    enable = 1'b1;
    apply_reset();
    wait_strobes(sb + NB + 1, 3 * NB * BIT_DIV, to);
    enable = 1'b0;
    wait_idle(2 * NB * BIT_DIV, t2);
    n_checks++;
    if (to || t2 || stb_cyc_q.size() - sb != 2 * NB)
      $display("FAIL par_bit_count: got %0d want %0d", stb_cyc_q.size() - sb, 2 * NB);
    else n_pass++;
    n_checks++;
    if (got_word(sb) !== 13'b0000000000010) $display("FAIL par_word001: got %b want 0000000000010", got_word(sb));
    else n_pass++;
    n_checks++;
    if (got_word(sb + NB) !== 13'b0000000000111) $display("FAIL par_word003: got %b want 0000000000111", got_word(sb + NB));
    else n_pass++;
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    reset    = 1'b1;
    enable   = 1'b0;
    dataWord = 12'h000;
    for (int i = 0; i < 256; i++) mem[i] = 12'h000;
    test_reset();
    test_first_fetch();
    test_continuous();
    test_enable_drop();
    test_reset_mid();
    test_random_runs();
`ifdef M2_PARITY_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
